fifo_ctrl: RTL and testbench
============================

# fifo_ctrl

Control side of the FIFO: it owns the write and read pointers, occupancy count and status flags, and drives the storage array's `write`, `read`, `ptr_write` and `ptr_read` ports. Producers and consumers talk to it through `push`/`pop` requests. Read data comes straight from the array's combinational output in the same cycle as the `read` strobe. The block sits beside the storage array inside the FIFO wrapper.

## Interface
- `LENGTH`, default 8: number of FIFO entries. Must equal 2**`PTR_W`.
- `PTR_W`, default 3: pointer width, matching the array's `ptr_write`/`ptr_read` width.
- `AF_THR`, default 2: almost-full margin. `almost_full` is asserted when count ≥ `LENGTH`−`AF_THR`.
- `AE_THR`, default 2: almost-empty margin. `almost_empty` is asserted when count ≤ `AE_THR`.

Ports:
- `clk` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `push` in 1: producer write request.
- `pop` in 1: consumer read request.
- `write` out 1: combinational write strobe to the array.
- `read` out 1: combinational read strobe to the array.
- `ptr_write` out `PTR_W`: array write address (registered).
- `ptr_read` out `PTR_W`: array read address (registered).
- `count` out `PTR_W`+1: occupancy, 0..`LENGTH` (registered).
- `full`, `empty`, `almost_full`, `almost_empty` out 1 each: registered status flags.
- `err` out 1: sticky overflow/underflow flag. Present only with `FIFO_CTRL_ERR_EN`.

## Operation
- Acceptance rules:
  - `rd_ok = pop & ~empty`.
  - `wr_ok = push & (~full | rd_ok)`.
  - Consequence: a push while full is accepted only if a pop is accepted in the same cycle.
- Output strobes: `read = rd_ok`, `write = wr_ok`. Neither strobe depends on anything else.
- Pointer update on a clock edge:
  - `ptr_write` += 1 on `wr_ok`.
  - `ptr_read` += 1 on `rd_ok`.
  - Both wrap modulo `LENGTH` (natural `PTR_W`-bit rollover).
- Count update:
  - +1 on `wr_ok` & ~`rd_ok`.
  - −1 on `rd_ok` & ~`wr_ok`.
  - Unchanged when both or neither occur.
- Flags are registered and computed from the next-count value, so they always agree with `count` in the same cycle:
  - `full` = (count == `LENGTH`).
  - `empty` = (count == 0).
  - Almost flags use the thresholds above.
- Empty + push + pop in the same cycle: pop is rejected (no bypass), push is accepted. Count goes 0→1.
- Full + push + pop in the same cycle: both are accepted and count stays at `LENGTH`. The array reads the old entry combinationally before the edge and writes the same slot at the edge, so this is safe.
- Rejected requests are dropped silently. The requester must hold or retry.
- Reset (asynchronous, takes effect mid-operation):
  - Pointers = 0, `count` = 0.
  - `empty` = 1, `almost_empty` = 1, `full` = 0, `almost_full` = 0, `err` = 0.
  - Strobes are held at 0 while `reset` is high.
  - Array contents are cleared by the array itself, not by this block.

## Timing
- Strobes are combinational from `push`, `pop` and the registered flags, with zero latency.
- Read data is valid in the cycle `read` is high.
- Pointers, count and flags update one edge after the accepted request.
- Pushes at full rate: `full` rises on the edge of the `LENGTH`-th accepted push. Likewise `empty` rises on the edge of the last accepted pop.
- There is no state machine beyond the pointer and count registers.

## Configuration
- `FIFO_CTRL_ERR_EN` defined:
  - `err` port exists.
  - It is set on the edge after `push & ~wr_ok` (overflow) or `pop & empty` (underflow).
  - It is cleared only by `reset`.
- `FIFO_CTRL_ERR_EN` undefined: the `err` port and its register are absent. Rejected requests remain silent.

## Structure
- Shared package/include `fifo_defs`:
  - Default `LENGTH` and `PTR_W`.
  - Threshold defaults.
  - Count-width constant (`PTR_W`+1).
- Sub-module `fifo_ptr`: a `PTR_W`-bit wrapping counter with an increment enable and asynchronous reset. It is instantiated twice, once for the write pointer and once for the read pointer.
- Count and flag logic stay in the top level.

## Test plan
All scenarios use the default parameters.
1. Reset, then 8 pushes →
   - `count` steps 1..8.
   - `ptr_write` goes 1..7, then 0.
   - `almost_full` rises at count 6.
   - `full` = 1 after the 8th push; `write` stays 0 on a 9th push.
2. From full, 8 pops →
   - `read` is high on each pop.
   - `ptr_read` steps 1..0 (wraps).
   - `almost_empty` rises at count 2.
   - `empty` = 1 at the end; a 9th pop gives `read` = 0.
3. Push and pop together while empty →
   - `write` = 1, `read` = 0, `count` = 1.
4. Push and pop together while full →
   - `write` = 1, `read` = 1, `count` stays 8, both pointers advance by 1.
5. Assert `reset` asynchronously mid-cycle at count 5 →
   - Pointers and `count` go to 0 immediately.
   - `empty` = 1.
   - Strobes are 0 while `reset` is held.
6. With `FIFO_CTRL_ERR_EN`:
   - Pop while empty → `err` = 1 on the next edge and it stays 1 through later valid traffic.
   - Without the macro, the `err` port is absent.

Source files
------------

// File: rtl/fifo_defs.sv
// rtl/fifo_defs.sv - shared FIFO sizing defaults and count-width helper
package fifo_defs;
  localparam int LENGTH_DEF = 8;
  localparam int PTR_W_DEF  = 3;
  localparam int AF_THR_DEF = 2;
  localparam int AE_THR_DEF = 2;
  localparam int CNT_W_DEF  = PTR_W_DEF + 1;

  // count needs one extra bit so a full FIFO (LENGTH) is distinguishable from empty
  function automatic int cnt_width(input int ptr_w);
    return ptr_w + 1;
  endfunction
endpackage

// File: rtl/fifo_ptr.sv
// rtl/fifo_ptr.sv - wrapping pointer counter with increment enable
module fifo_ptr #(
  parameter int PTR_W = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  output logic [PTR_W-1:0] ptr
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) ptr <= '0;
    else if (inc) ptr <= ptr + PTR_W'(1);
  end

endmodule

// File: rtl/fifo_ctrl.sv
// rtl/fifo_ctrl.sv - FIFO pointer/count/flag control; FIFO_CTRL_ERR_EN adds sticky err
module fifo_ctrl
  import fifo_defs::*;
#(
  parameter int LENGTH = LENGTH_DEF,
  parameter int PTR_W  = PTR_W_DEF,
  parameter int AF_THR = AF_THR_DEF,
  parameter int AE_THR = AE_THR_DEF
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 push,
  input  logic                 pop,
  output logic                 write,
  output logic                 read,
  output logic [PTR_W-1:0]     ptr_write,
  output logic [PTR_W-1:0]     ptr_read,
  output logic [PTR_W:0]       count,
  output logic                 full,
  output logic                 empty,
  output logic                 almost_full,
`ifdef FIFO_CTRL_ERR_EN
  output logic                 almost_empty,
  output logic                 err
`else
  output logic                 almost_empty
`endif
);

  localparam int CNT_W = cnt_width(PTR_W);
  localparam logic [CNT_W-1:0] LEN_C = CNT_W'(LENGTH);
  localparam logic [CNT_W-1:0] AF_C  = CNT_W'(LENGTH - AF_THR);
  localparam logic [CNT_W-1:0] AE_C  = CNT_W'(AE_THR);

  logic             rd_ok;
  logic             wr_ok;
  logic [CNT_W-1:0] count_next;

  // reset gating keeps strobes quiet even though full is low during reset
  assign rd_ok = pop & ~empty & ~reset;
  assign wr_ok = push & (~full | rd_ok) & ~reset;
  assign read  = rd_ok;
  assign write = wr_ok;

  fifo_ptr #(.PTR_W(PTR_W)) u_wr_ptr (
    .clk   (clk),
    .reset (reset),
    .inc   (wr_ok),
    .ptr   (ptr_write)
  );

  fifo_ptr #(.PTR_W(PTR_W)) u_rd_ptr (
    .clk   (clk),
    .reset (reset),
    .inc   (rd_ok),
    .ptr   (ptr_read)
  );

  always_comb begin
    count_next = count;
    if (wr_ok && !rd_ok)      count_next = count + CNT_W'(1);
    else if (rd_ok && !wr_ok) count_next = count - CNT_W'(1);
  end

  // flags derive from count_next so they land on the same edge as count
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count        <= '0;
      full         <= 1'b0;
      empty        <= 1'b1;
      almost_full  <= 1'b0;
      almost_empty <= 1'b1;
    end else begin
      count        <= count_next;
      full         <= (count_next == LEN_C);
      empty        <= (count_next == '0);
      almost_full  <= (count_next >= AF_C);
      almost_empty <= (count_next <= AE_C);
    end
  end

`ifdef FIFO_CTRL_ERR_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) err <= 1'b0;
    else if ((push && !wr_ok) || (pop && empty)) err <= 1'b1;
  end
`endif

endmodule

// File: tb/tb_fifo_ctrl.sv
// tb/tb_fifo_ctrl.sv - directed vector bench for fifo_ctrl (FIFO_CTRL_ERR_EN optional)
module tb_fifo_ctrl;

  logic       clk;
  logic       reset;
  logic       push;
  logic       pop;
  logic       write;
  logic       read;
  logic [2:0] ptr_write;
  logic [2:0] ptr_read;
  logic [3:0] count;
  logic       full;
  logic       empty;
  logic       almost_full;
  logic       almost_empty;
`ifdef FIFO_CTRL_ERR_EN
  logic       err;
`endif

  int tests_run;
  int tests_failed;

  fifo_ctrl dut (
    .clk          (clk),
    .reset        (reset),
    .push         (push),
    .pop          (pop),
    .write        (write),
    .read         (read),
    .ptr_write    (ptr_write),
    .ptr_read     (ptr_read),
    .count        (count),
    .full         (full),
    .empty        (empty),
    .almost_full  (almost_full),
`ifdef FIFO_CTRL_ERR_EN
    .almost_empty (almost_empty),
    .err          (err)
`else
    .almost_empty (almost_empty)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit push;
    bit pop;
    bit exp_write;
    bit exp_read;
    int exp_count;
    int exp_pw;
    int exp_pr;
    bit exp_full;
    bit exp_empty;
    bit exp_af;
    bit exp_ae;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(bit p, bit q, bit w, bit r, int c, int pw, int pr,
                              bit f, bit e, bit af, bit ae);
    vec_t v;
    v.push = p; v.pop = q; v.exp_write = w; v.exp_read = r;
    v.exp_count = c; v.exp_pw = pw; v.exp_pr = pr;
    v.exp_full = f; v.exp_empty = e; v.exp_af = af; v.exp_ae = ae;
    return v;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    tests_run++;
    if (act != exp) begin
      tests_failed++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_state(input string tag, input int c, input int pw, input int pr,
                           input bit f, input bit e, input bit af, input bit ae);
    chk({tag, " count"}, int'(count), c);
    chk({tag, " ptr_write"}, int'(ptr_write), pw);
    chk({tag, " ptr_read"}, int'(ptr_read), pr);
    chk({tag, " full"}, int'(full), int'(f));
    chk({tag, " empty"}, int'(empty), int'(e));
    chk({tag, " almost_full"}, int'(almost_full), int'(af));
    chk({tag, " almost_empty"}, int'(almost_empty), int'(ae));
  endtask

  initial begin
    tests_run = 0;
    tests_failed = 0;
    push = 1'b0;
    pop = 1'b0;
    reset = 1'b1;

    // scenario 1: fill, then overflow attempt
    vecs.push_back(mk(1,0,1,0,1,1,0,0,0,0,1));
    vecs.push_back(mk(1,0,1,0,2,2,0,0,0,0,1));
    vecs.push_back(mk(1,0,1,0,3,3,0,0,0,0,0));
    vecs.push_back(mk(1,0,1,0,4,4,0,0,0,0,0));
    vecs.push_back(mk(1,0,1,0,5,5,0,0,0,0,0));
    vecs.push_back(mk(1,0,1,0,6,6,0,0,0,1,0));
    vecs.push_back(mk(1,0,1,0,7,7,0,0,0,1,0));
    vecs.push_back(mk(1,0,1,0,8,0,0,1,0,1,0));
    vecs.push_back(mk(1,0,0,0,8,0,0,1,0,1,0));
    // scenario 2: drain, then underflow attempt
    vecs.push_back(mk(0,1,0,1,7,0,1,0,0,1,0));
    vecs.push_back(mk(0,1,0,1,6,0,2,0,0,1,0));
    vecs.push_back(mk(0,1,0,1,5,0,3,0,0,0,0));
    vecs.push_back(mk(0,1,0,1,4,0,4,0,0,0,0));
    vecs.push_back(mk(0,1,0,1,3,0,5,0,0,0,0));
    vecs.push_back(mk(0,1,0,1,2,0,6,0,0,0,1));
    vecs.push_back(mk(0,1,0,1,1,0,7,0,0,0,1));
    vecs.push_back(mk(0,1,0,1,0,0,0,0,1,0,1));
    vecs.push_back(mk(0,1,0,0,0,0,0,0,1,0,1));
    // scenario 3: push+pop while empty
    vecs.push_back(mk(1,1,1,0,1,1,0,0,0,0,1));
    // refill to full
    vecs.push_back(mk(1,0,1,0,2,2,0,0,0,0,1));
    vecs.push_back(mk(1,0,1,0,3,3,0,0,0,0,0));
    vecs.push_back(mk(1,0,1,0,4,4,0,0,0,0,0));
    vecs.push_back(mk(1,0,1,0,5,5,0,0,0,0,0));
    vecs.push_back(mk(1,0,1,0,6,6,0,0,0,1,0));
    vecs.push_back(mk(1,0,1,0,7,7,0,0,0,1,0));
    vecs.push_back(mk(1,0,1,0,8,0,0,1,0,1,0));
    // scenario 4: push+pop while full
    vecs.push_back(mk(1,1,1,1,8,1,1,1,0,1,0));
    vecs.push_back(mk(0,0,0,0,8,1,1,1,0,1,0));
    // drain three to reach count 5
    vecs.push_back(mk(0,1,0,1,7,1,2,0,0,1,0));
    vecs.push_back(mk(0,1,0,1,6,1,3,0,0,1,0));
    vecs.push_back(mk(0,1,0,1,5,1,4,0,0,0,0));

    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    chk("reset strobe write", int'(write), 0);
    chk("reset strobe read", int'(read), 0);
    chk_state("reset", 0, 0, 0, 0, 1, 0, 1);
`ifdef FIFO_CTRL_ERR_EN
    chk("reset err", int'(err), 0);
`endif
    reset = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      push = vecs[i].push;
      pop  = vecs[i].pop;
      #1;
      chk($sformatf("v%0d write", i), int'(write), int'(vecs[i].exp_write));
      chk($sformatf("v%0d read", i), int'(read), int'(vecs[i].exp_read));
      @(posedge clk);
      #1;
      chk_state($sformatf("v%0d", i), vecs[i].exp_count, vecs[i].exp_pw, vecs[i].exp_pr,
                vecs[i].exp_full, vecs[i].exp_empty, vecs[i].exp_af, vecs[i].exp_ae);
    end

    // scenario 5: asynchronous reset mid-cycle at count 5
    #2;
    push  = 1'b1;
    pop   = 1'b1;
    reset = 1'b1;
    #1;
    chk_state("async rst", 0, 0, 0, 0, 1, 0, 1);
    chk("async rst write", int'(write), 0);
    chk("async rst read", int'(read), 0);
    @(posedge clk);
    #1;
    chk("rst held write", int'(write), 0);
    chk("rst held read", int'(read), 0);
    chk("rst held count", int'(count), 0);
    @(negedge clk);
    push  = 1'b0;
    pop   = 1'b0;
    reset = 1'b0;

`ifdef FIFO_CTRL_ERR_EN
    // scenario 6: underflow sets sticky err
    #1;
    chk("err clear after rst", int'(err), 0);
    @(negedge clk);
    pop = 1'b1;
    @(posedge clk);
    #1;
    chk("err after underflow", int'(err), 1);
    @(negedge clk);
    pop  = 1'b0;
    push = 1'b1;
    @(posedge clk);
    #1;
    chk("err sticky push", int'(err), 1);
    @(negedge clk);
    push = 1'b1;
    pop  = 1'b1;
    @(posedge clk);
    #1;
    chk("err sticky push+pop", int'(err), 1);
    chk("err scen count", int'(count), 1);
    @(negedge clk);
    push = 1'b0;
    pop  = 1'b0;
`endif

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
